// File: rtl/spi_cmd_receiver_if.sv
// Bundles the SPI pins and the decoded register-write outputs of spi_cmd_receiver.
// The host drives the pins through the master modport; the receiver uses the slave modport.
interface spi_cmd_receiver_if #(
    parameter int FRAME_BITS = 16
);
    logic                  spi_cs_n;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [FRAME_BITS-1:0] data;
    logic                  data_valid;
    logic [7:0]            pwm_wr;
    logic                  clk_div_wr;
    logic                  frame_err;

    modport master (
        output spi_cs_n, spi_sck, spi_mosi,
        input  spi_miso, spi_miso_oe, data, data_valid, pwm_wr, clk_div_wr, frame_err
    );

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi,
        output spi_miso, spi_miso_oe, data, data_valid, pwm_wr, clk_div_wr, frame_err
    );
endinterface

// File: rtl/spi_cmd_receiver.sv
// SPI mode-0 slave: oversamples the pins, assembles command frames, publishes data plus write strobes.
// Define SPI_ECHO_EN to shift the previous valid frame back out on spi_miso during each frame.
//
// state     | meaning
// WAIT_IDLE | after reset; waits for settled synchronizers and cs_n high
// IDLE      | no frame; waiting for a cs_n falling edge
// SHIFT     | frame in progress; sampling mosi on sck rising edges
module spi_cmd_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    spi_cmd_receiver_if.slave bus
);
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_hist, sck_hist;
    logic [SYNC_STAGES:0]   prime_sr;
    logic                   cs_s, sck_s, mosi_s, sync_primed;
    logic                   cs_fall, cs_rise, sck_rise;

    logic [FRAME_BITS-1:0]  shift_reg, data_q;
    logic [CW-1:0]          bit_cnt;
    logic [3:0]             addr;
    logic                   start_frame, shift_en, end_frame, frame_ok, frame_bad;
    logic                   data_valid_q, clk_div_wr_q, frame_err_q;
    logic [7:0]             pwm_wr_q;

    // Sync chains reset to the idle pin levels; prime_sr marks when they hold real pin samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_hist   <= 1'b1;
            sck_hist  <= 1'b0;
            prime_sr  <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            prime_sr  <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sync_primed = prime_sr[SYNC_STAGES];
    assign cs_fall     = cs_hist & ~cs_s;
    assign cs_rise     = ~cs_hist & cs_s;
    assign sck_rise    = ~sck_hist & sck_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (sync_primed && cs_s) state_nxt = IDLE;
            IDLE:      if (cs_fall)             state_nxt = SHIFT;
            SHIFT:     if (cs_rise)             state_nxt = IDLE;
            default:                            state_nxt = WAIT_IDLE;
        endcase
    end

    // A cs_n rise takes priority over an sck rise seen in the same cycle.
    always_comb begin
        start_frame = (state == IDLE) && cs_fall;
        shift_en    = (state == SHIFT) && !cs_rise && sck_rise;
        end_frame   = (state == SHIFT) && cs_rise;
        frame_ok    = end_frame && (bit_cnt == CNT_FULL);
        frame_bad   = end_frame && (bit_cnt != CNT_FULL);
    end

    assign addr = shift_reg[FRAME_BITS-1 -: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            pwm_wr_q     <= '0;
            clk_div_wr_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (start_frame) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (frame_ok) data_q <= shift_reg;
            data_valid_q <= frame_ok;
            frame_err_q  <= frame_bad;
            pwm_wr_q     <= (frame_ok && !addr[3]) ? (8'd1 << addr[2:0]) : 8'd0;
            clk_div_wr_q <= frame_ok && (addr == 4'd8);
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.pwm_wr     = pwm_wr_q;
    assign bus.clk_div_wr = clk_div_wr_q;
    assign bus.frame_err  = frame_err_q;

`ifdef SPI_ECHO_EN
    logic                  sck_fall;
    logic [FRAME_BITS-1:0] tx_sr;

    assign sck_fall = sck_hist & ~sck_s;

    // Zeros shift in behind the echoed word so miso idles low once it is exhausted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= '0;
        end else if (start_frame) begin
            tx_sr <= data_q;
        end else if ((state == SHIFT) && sck_fall) begin
            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign bus.spi_miso    = (state == SHIFT) && tx_sr[FRAME_BITS-1];
    assign bus.spi_miso_oe = (state == SHIFT);
`else
    assign bus.spi_miso    = 1'b0;
    assign bus.spi_miso_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Scoreboard bench for spi_cmd_receiver: directed SPI frames push expected events, a monitor pops them.
// With SPI_ECHO_EN defined, miso is also checked against the previously accepted frame.
module tb_spi_cmd_receiver;
    localparam int FB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_receiver_if #(.FRAME_BITS(FB)) bus ();

    spi_cmd_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [15:0] data;
        logic [7:0]  pwm;
        logic        cdw;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_data = 16'h0;
    logic [31:0] echo_exp = 32'h0;
    logic        expect_shift = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ok(input logic [15:0] d, input logic [7:0] pwm, input logic cdw);
        exp_t e;
        e = '{valid: 1'b1, err: 1'b0, data: d, pwm: pwm, cdw: cdw};
        exp_q.push_back(e);
        last_data = d;
    endtask

    task automatic expect_err();
        exp_t e;
        e = '{valid: 1'b0, err: 1'b1, data: last_data, pwm: 8'h00, cdw: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        bus.spi_cs_n = 1'b0;
        echo_exp     = {last_data, 16'h0};
        expect_shift = 1'b1;
        clk_wait(5);
    endtask

    task automatic send_bit(input logic b);
        bus.spi_mosi = b;
        clk_wait(5);
`ifdef SPI_ECHO_EN
        check("echo_miso", {31'h0, bus.spi_miso}, {31'h0, echo_exp[31] & expect_shift});
        check("echo_oe", {31'h0, bus.spi_miso_oe}, {31'h0, expect_shift});
`else
        check("miso_idle", {30'h0, bus.spi_miso, bus.spi_miso_oe}, 32'h0);
`endif
        echo_exp = echo_exp << 1;
        bus.spi_sck = 1'b1;
        clk_wait(5);
        bus.spi_sck = 1'b0;
    endtask

    task automatic frame_end();
        clk_wait(5);
        bus.spi_cs_n = 1'b1;
        clk_wait(10);
        expect_shift = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits);
        frame_start();
        for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
        frame_end();
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.data_valid || bus.frame_err || (bus.pwm_wr != 8'h0) || bus.clk_div_wr)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got valid=%b err=%b pwm=%h cdw=%b data=%h, required no event",
                         bus.data_valid, bus.frame_err, bus.pwm_wr, bus.clk_div_wr, bus.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_valid", {31'h0, bus.data_valid}, {31'h0, e.valid});
                check("frame_err", {31'h0, bus.frame_err}, {31'h0, e.err});
                check("data", {16'h0, bus.data}, {16'h0, e.data});
                check("pwm_wr", {24'h0, bus.pwm_wr}, {24'h0, e.pwm});
                check("clk_div_wr", {31'h0, bus.clk_div_wr}, {31'h0, e.cdw});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d events pending", exp_q.size());
        n_bad++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        rst_n = 1'b0;
        clk_wait(3);
        check("rst_data", {16'h0, bus.data}, 32'h0);
        check("rst_flags", {28'h0, bus.data_valid, bus.frame_err, bus.clk_div_wr, bus.spi_miso}, 32'h0);
        check("rst_pwm_oe", {23'h0, bus.pwm_wr, bus.spi_miso_oe}, 32'h0);
        rst_n = 1'b1;
        clk_wait(10);

        expect_ok(16'h3155, 8'h08, 1'b0);
        send_frame(32'h3155, 16);
        expect_ok(16'h8007, 8'h00, 1'b1);
        send_frame(32'h8007, 16);
        expect_ok(16'hA123, 8'h00, 1'b0);
        send_frame(32'hA123, 16);

        expect_err();
        send_frame(32'h4321, 15);
        expect_err();
        send_frame(32'h1_2345, 17);

        // Reset in mid-frame with cs_n held low: the tail of that frame must be discarded.
        frame_start();
        for (int i = 15; i >= 8; i--) send_bit(1'(16'h7001 >> i));
        rst_n = 1'b0;
        clk_wait(3);
        expect_shift = 1'b0;
        last_data    = 16'h0;
        rst_n = 1'b1;
        check("data_after_reset", {16'h0, bus.data}, 32'h0);
        for (int i = 7; i >= 0; i--) send_bit(1'(16'h7001 >> i));
        frame_end();

        expect_ok(16'h7001, 8'h80, 1'b0);
        send_frame(32'h7001, 16);

        // 17th sck rise coincides with the cs_n rise and must not be counted.
        frame_start();
        for (int i = 15; i >= 0; i--) send_bit(1'(16'h5A5A >> i));
        bus.spi_mosi = 1'b1;
        clk_wait(5);
        expect_ok(16'h5A5A, 8'h20, 1'b0);
        bus.spi_sck  = 1'b1;
        bus.spi_cs_n = 1'b1;
        clk_wait(5);
        bus.spi_sck  = 1'b0;
        clk_wait(10);
        expect_shift = 1'b0;

        expect_ok(16'h2ABC, 8'h04, 1'b0);
        send_frame(32'h2ABC, 16);
        expect_ok(16'h0000, 8'h01, 1'b0);
        send_frame(32'h0000, 16);
        check("oe_after_frame", {31'h0, bus.spi_miso_oe}, 32'h0);

        clk_wait(20);
        check("queue_drained", exp_q.size(), 32'h0);
        summary();
        $finish;
    end
endmodule
